// File: rtl/queue_pkg.sv
// Shared helpers for the stream blocks (queue, repack, unpack).
// Handshake: a word moves when stb && rdy at a rising clk edge.
package queue_pkg;

    // stb/rdy handshake used by every stream port in this datapath:
    //   the producer raises stb with data and holds both until rdy;
    //   the consumer raises rdy when it can take a word;
    //   a transfer happens on a rising clk edge where stb && rdy;
    //   stb never depends combinationally on rdy.

    // Ceiling log2, used for pointer and count widths.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/queue_ram.sv
// Storage for queue: 2**D x W, synchronous write, registered look-ahead read.
// Write-to-read-address collisions forward the write data into the read register.
module queue_ram
    import queue_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we_i,
    input  logic [D-1:0] waddr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         re_i,
    input  logic [D-1:0] raddr_i,
    output logic [W-1:0] rdata_o
);

    localparam int N = 1 << D;

    logic [W-1:0] mem_q [N];
    logic [W-1:0] rdata_q;
    logic [W-1:0] rdata_d;

    // Array contents are never reset so the array maps to block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Next head word: forward the write if it lands on the read address.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            if (we_i && (waddr_i == raddr_i)) begin
                rdata_d = wdata_i;
            end else begin
                rdata_d = mem_q[raddr_i];
            end
        end
    end

    // Read register only loads when a valid head exists, keeping it X-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/queue.sv
// Synchronous stb/rdy stream FIFO, 2**D words of W bits.
// Optional macro QUEUE_LEVEL_EN adds the lvl fill-level output.
module queue
    import queue_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_stb,
    input  logic [W-1:0] s_dat,
    output logic         s_rdy,
    output logic         m_stb,
    output logic [W-1:0] m_dat,
    input  logic         m_rdy
`ifdef QUEUE_LEVEL_EN
   ,output logic [D:0]   lvl
`endif
);

    localparam int DEPTH = 1 << D;
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          push;
    logic          pop;
    logic          ram_we;
    logic          ram_re;

    // Flags come straight from the count register.
    assign s_rdy = (cnt_q != FULL);
    assign m_stb = (cnt_q != '0);

    assign push = s_stb && s_rdy;
    assign pop  = m_stb && m_rdy;

    // Pointer and count next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers; reset drops all queued words.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head reloads when it advances, or when the first word enters an
    // empty queue; only while a next head actually exists.
    assign ram_we = push && !rst;
    assign ram_re = !rst && (cnt_d != '0) && (pop || (cnt_q == '0));

    queue_ram #(
        .W (W),
        .D (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (s_dat),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_d),
        .rdata_o (m_dat)
    );

`ifdef QUEUE_LEVEL_EN
    assign lvl = cnt_q;
`endif

endmodule
